swc_rd_sched: RTL and testbench

- Weighted round-robin scheduler for the switch core read side.
- Arbitrates among the per-port queue controllers (ptr_rdy/ptr_ack pairs) for the single shared data-RAM read engine, one cell per grant.
- Masks backpressured output ports and issues the ptr_ack pulse to the winning queue controller.
- Holds the grant until the read engine signals completion, with a watchdog for a lost completion.

---
 rtl/swc_rd_sched.sv | 153 +++++++++++++++
 tb/tb_swc_rd_sched.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/swc_rd_sched.sv
// Weighted round-robin read scheduler: grants the shared data-RAM read engine to one queue per cell.
// Optional per-port grant statistics are enabled by defining SWC_RD_SCHED_STATS_EN.
module swc_rd_sched #(
    parameter int NPORT          = 4,
    parameter int WEIGHT_W       = 4,
    parameter int DEFAULT_WEIGHT = 1,
    parameter int TIMEOUT        = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NPORT-1:0]         ptr_rdy,
    input  logic [NPORT-1:0]         o_cell_bp,
    output logic [NPORT-1:0]         ptr_ack,
    output logic                     grant_valid,
    output logic [NPORT-1:0]         grant_port,
    input  logic                     rd_done,
    input  logic                     cfg_wr,
    input  logic [$clog2(NPORT)-1:0] cfg_port,
    input  logic [WEIGHT_W-1:0]      cfg_weight,
    output logic                     err_timeout
`ifdef SWC_RD_SCHED_STATS_EN
    ,
    input  logic [$clog2(NPORT)-1:0] stat_sel,
    input  logic                     stat_clr,
    output logic [15:0]              stat_cnt
`endif
);
    localparam int PW = $clog2(NPORT);
    localparam int TW = $clog2(TIMEOUT) + 1;

    typedef enum logic {IDLE, WAIT} state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       cur, cur_nx;
    logic [WEIGHT_W-1:0] credit, credit_nx;
    logic [WEIGHT_W-1:0] weight [NPORT];
    logic [TW-1:0]       wdog;
    logic                ack_pend;
    logic [NPORT-1:0]    elig;
    logic                pick_vld;
    logic [PW-1:0]       pick_port;
    logic [WEIGHT_W-1:0] pick_credit;
    logic [PW-1:0]       idx;
    logic                wd_exp;

    always_comb begin
        for (int unsigned p = 0; p < NPORT; p++) begin
            elig[p] = ptr_rdy[p] & ~o_cell_bp[p] & (weight[p] != '0);
        end
    end

    // Current port keeps the grant while it has credit; otherwise scan from cur+1, cur last.
    always_comb begin
        pick_vld    = 1'b0;
        pick_port   = cur;
        pick_credit = credit;
        idx         = '0;
        if (elig[cur] && credit != '0) begin
            pick_vld    = 1'b1;
            pick_credit = credit - 1'b1;
        end else begin
            for (int unsigned i = 1; i <= NPORT; i++) begin
                idx = PW'((32'(cur) + i) % NPORT);
                if (!pick_vld && elig[idx]) begin
                    pick_vld    = 1'b1;
                    pick_port   = idx;
                    pick_credit = weight[idx] - 1'b1;
                end
            end
        end
    end

    assign wd_exp = (wdog == TW'(TIMEOUT - 1));

    always_comb begin
        cur_nx    = cur;
        credit_nx = credit;
        if (state == IDLE && pick_vld) begin
            cur_nx    = pick_port;
            credit_nx = pick_credit;
        end
        // Disabling the port that owns the credit drops its remaining credit.
        if (cfg_wr && cfg_weight == '0 && cfg_port == cur_nx) begin
            credit_nx = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (pick_vld) state_nx = WAIT;
            WAIT:    if (rd_done || wd_exp) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur         <= PW'(NPORT - 1);
            credit      <= '0;
            wdog        <= '0;
            ack_pend    <= 1'b0;
            err_timeout <= 1'b0;
            for (int unsigned p = 0; p < NPORT; p++) begin
                weight[p] <= WEIGHT_W'(DEFAULT_WEIGHT);
            end
        end else begin
            cur      <= cur_nx;
            credit   <= credit_nx;
            ack_pend <= (state == IDLE) && pick_vld;
            wdog     <= (state == IDLE) ? '0 : wdog + 1'b1;
            if (state == WAIT && wd_exp && !rd_done) begin
                err_timeout <= 1'b1;
            end
            if (cfg_wr) begin
                weight[cfg_port] <= cfg_weight;
            end
        end
    end

    always_comb begin
        grant_valid = (state == WAIT);
        grant_port  = '0;
        ptr_ack     = '0;
        if (state == WAIT) grant_port[cur] = 1'b1;
        if (ack_pend)      ptr_ack[cur]    = 1'b1;
    end

`ifdef SWC_RD_SCHED_STATS_EN
    logic [15:0] cnt [NPORT];

    always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
            for (int unsigned p = 0; p < NPORT; p++) cnt[p] <= '0;
        end else begin
            for (int unsigned p = 0; p < NPORT; p++) begin
                if (ptr_ack[p] && cnt[p] != '1) cnt[p] <= cnt[p] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) stat_cnt <= '0;
        else     stat_cnt <= cnt[stat_sel];
    end
`endif

endmodule

// File: tb/tb_swc_rd_sched.sv
// Bench for swc_rd_sched: directed test-plan scenarios plus randomized traffic,
// checked every cycle against a transaction-level scheduling model.
module tb_swc_rd_sched;
    localparam int NPORT    = 4;
    localparam int WEIGHT_W = 4;
    localparam int TIMEOUT  = 64;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic [NPORT-1:0] ptr_rdy = '0;
    logic [NPORT-1:0] o_cell_bp = '0;
    logic [NPORT-1:0] ptr_ack;
    logic             grant_valid;
    logic [NPORT-1:0] grant_port;
    logic             rd_done = 1'b0;
    logic             cfg_wr = 1'b0;
    logic [1:0]       cfg_port = '0;
    logic [WEIGHT_W-1:0] cfg_weight = '0;
    logic             err_timeout;

    swc_rd_sched #(
        .NPORT(NPORT),
        .WEIGHT_W(WEIGHT_W),
        .DEFAULT_WEIGHT(1),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .ptr_rdy(ptr_rdy),
        .o_cell_bp(o_cell_bp),
        .ptr_ack(ptr_ack),
        .grant_valid(grant_valid),
        .grant_port(grant_port),
        .rd_done(rd_done),
        .cfg_wr(cfg_wr),
        .cfg_port(cfg_port),
        .cfg_weight(cfg_weight),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scheduling model: a busy flag with an age counter, per-port weights and one credit pool.
    bit m_valid = 0;
    bit m_busy, m_ack, m_err;
    int m_cur, m_credit, m_age, m_gp;
    int m_w [NPORT];
    int ack_q [$];

    function automatic bit m_elig(input int p);
        return ptr_rdy[p] && !o_cell_bp[p] && m_w[p] != 0;
    endfunction

    always @(posedge clk) begin
        int p;
        int q;
        if (rst) begin
            m_valid  = 1;
            m_busy   = 0;
            m_ack    = 0;
            m_err    = 0;
            m_cur    = NPORT - 1;
            m_credit = 0;
            m_age    = 0;
            m_gp     = 0;
            foreach (m_w[i]) m_w[i] = 1;
        end else if (m_valid) begin
            m_ack = 0;
            p = -1;
            if (!m_busy) begin
                if (m_elig(m_cur) && m_credit > 0) begin
                    p = m_cur;
                    m_credit = m_credit - 1;
                end else begin
                    for (int i = 1; i <= NPORT; i++) begin
                        q = (m_cur + i) % NPORT;
                        if (p < 0 && m_elig(q)) p = q;
                    end
                    if (p >= 0) begin
                        m_cur = p;
                        m_credit = m_w[p] - 1;
                    end
                end
                if (p >= 0) begin
                    m_busy = 1;
                    m_age  = 0;
                    m_ack  = 1;
                    m_gp   = p;
                    ack_q.push_back(p);
                end
            end else begin
                if (rd_done || m_age == TIMEOUT - 1) begin
                    if (!rd_done) m_err = 1;
                    m_busy = 0;
                end else begin
                    m_age++;
                end
            end
            if (cfg_wr) begin
                m_w[cfg_port] = cfg_weight;
                if (cfg_weight == 0 && int'(cfg_port) == m_cur) m_credit = 0;
            end
        end
    end

    // Read-engine responder: 0 = rd_done after rd_delay grant cycles, 1 = never, 2 = random pulses.
    int rd_mode = 0;
    int rd_delay = 2;
    int gv_cnt = 0;

    always @(negedge clk) begin
        if (m_valid) begin
            check("ptr_ack", ptr_ack, m_ack ? (1 << m_gp) : 0);
            check("grant_valid", grant_valid, m_busy);
            check("grant_port", grant_port, m_busy ? (1 << m_gp) : 0);
            check("err_timeout", err_timeout, m_err);
        end
        if (grant_valid) gv_cnt++;
        else             gv_cnt = 0;
        case (rd_mode)
            0:       rd_done = (gv_cnt == rd_delay);
            2:       rd_done = ($urandom_range(0, 2) == 0);
            default: rd_done = 1'b0;
        endcase
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        ptr_rdy   = '0;
        o_cell_bp = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ack_q.delete();
    endtask

    task automatic cfg(input int port, input int w);
        cfg_wr     = 1'b1;
        cfg_port   = 2'(port);
        cfg_weight = WEIGHT_W'(w);
        @(negedge clk);
        cfg_wr = 1'b0;
    endtask

    task automatic wait_acks(input string name, input int n);
        int t;
        t = 0;
        while (ack_q.size() < n && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (ack_q.size() < n) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got %0d acks expected %0d before cycle limit", name, ack_q.size(), n);
        end
    endtask

    task automatic check_seq(input string name, input int exp[$]);
        for (int i = 0; i < exp.size(); i++) begin
            check(name, (i < ack_q.size()) ? ack_q[i] : -1, exp[i]);
        end
    endtask

    initial begin
        int len;
        int t;

        // Plain round robin, weights 1
        rd_mode = 0;
        rd_delay = 2;
        do_reset();
        check("rst_grant_valid", grant_valid, 0);
        check("rst_ptr_ack", ptr_ack, 0);
        check("rst_err", err_timeout, 0);
        ptr_rdy = 4'hF;
        wait_acks("rr", 5);
        ptr_rdy = '0;
        check_seq("rr_order", '{0, 1, 2, 3, 0});
        tick(6);

        // Weight 3 on port 0
        do_reset();
        cfg(0, 3);
        ptr_rdy = 4'hF;
        wait_acks("wrr", 10);
        ptr_rdy = '0;
        check_seq("wrr_order", '{0, 0, 0, 1, 2, 3, 0, 0, 0, 1});
        tick(6);

        // Backpressure on port 1, then released
        do_reset();
        o_cell_bp = 4'b0010;
        ptr_rdy = 4'hF;
        wait_acks("bp", 4);
        check_seq("bp_order", '{0, 2, 3, 0});
        o_cell_bp = '0;
        wait_acks("bp_rel", 5);
        ptr_rdy = '0;
        check("bp_release", (ack_q.size() > 4) ? ack_q[4] : -1, 1);
        tick(6);

        // Port 2 disabled by weight 0, then weight 2
        do_reset();
        ptr_rdy = 4'hF;
        cfg(2, 0);
        wait_acks("w0", 6);
        ptr_rdy = '0;
        check_seq("w0_order", '{0, 1, 3, 0, 1, 3});
        tick(6);
        ack_q.delete();
        cfg(2, 2);
        ptr_rdy = 4'hF;
        wait_acks("w2", 6);
        ptr_rdy = '0;
        check_seq("w2_order", '{0, 1, 2, 2, 3, 0});
        tick(6);

        // Lost completion: watchdog abort
        do_reset();
        rd_mode = 1;
        ptr_rdy = 4'b0001;
        wait_acks("wd", 1);
        ptr_rdy = 4'hF;
        len = 1;
        t = 0;
        while (m_busy && t < 200) begin
            @(negedge clk);
            t++;
            if (m_busy) len++;
        end
        rd_mode = 0;
        check("wd_grant_len", len, TIMEOUT);
        check("wd_model_err", m_err, 1);
        check("wd_err_flag", err_timeout, 1);
        wait_acks("wd_next", 2);
        ptr_rdy = '0;
        check("wd_next_port", (ack_q.size() > 1) ? ack_q[1] : -1, 1);
        tick(6);
        check("wd_err_sticky", err_timeout, 1);

        // Reset while in WAIT
        rd_mode = 1;
        ack_q.delete();
        ptr_rdy = 4'hF;
        wait_acks("rstw", 1);
        tick(3);
        rst = 1'b1;
        @(negedge clk);
        check("rstw_grant_valid", grant_valid, 0);
        check("rstw_ptr_ack", ptr_ack, 0);
        check("rstw_err", err_timeout, 0);
        rst = 1'b0;
        rd_mode = 0;
        ack_q.delete();
        wait_acks("rstw_first", 1);
        ptr_rdy = '0;
        check("rstw_first_port", (ack_q.size() > 0) ? ack_q[0] : -1, 0);
        tick(6);

        // Randomized traffic, weights, completions and occasional resets
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 50 == 0) begin
                rd_mode  = ($urandom_range(0, 9) == 0) ? 1 : int'($urandom_range(0, 1)) * 2;
                rd_delay = $urandom_range(1, 4);
            end
            ptr_rdy    = NPORT'($urandom);
            o_cell_bp  = NPORT'($urandom & $urandom);
            cfg_wr     = ($urandom_range(0, 9) == 0);
            cfg_port   = 2'($urandom);
            cfg_weight = WEIGHT_W'($urandom_range(0, 3));
            rst        = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0;
        cfg_wr = 1'b0;
        ptr_rdy = '0;
        o_cell_bp = '0;
        rd_mode = 0;
        tick(80);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
